// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered round-robin arbitrated N-to-1 mux with valid/ready handshakes and packet locking
module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 8,
  parameter int WSEL   = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH*INPUTS-1:0] in_data,
  input  logic [INPUTS-1:0]       in_valid,
  input  logic [INPUTS-1:0]       in_last,
  output logic [INPUTS-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [WSEL-1:0]         out_sel,
  input  logic                    out_ready
);
  logic [WSEL-1:0] ptr, lock_ch, grant;
  logic lock, grant_valid, load_en, xfer;
  // a locked packet owns the mux; otherwise the first valid channel at or after ptr wins
  always_comb begin
    int j;
    j = 0;
    grant = lock_ch;
    grant_valid = in_valid[lock_ch];
    if (!lock) begin
      grant = '0;
      grant_valid = 1'b0;
      for (int i = INPUTS - 1; i >= 0; i--) begin
        j = int'(ptr) + i;
        j = j >= INPUTS ? j - INPUTS : j;
        if (in_valid[j]) begin
          grant = WSEL'(j);
          grant_valid = 1'b1;
        end
      end
    end
  end
  assign load_en  = ~out_valid | out_ready;
  assign xfer     = reset & load_en & grant_valid;
  assign in_ready = xfer ? INPUTS'(1) << grant : '0;
  // output register plus arbitration state; a packet end releases the lock and advances ptr past the winner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
      lock      <= 1'b0;
      lock_ch   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_last  <= in_last[grant];
      out_sel   <= grant;
      lock      <= ~in_last[grant];
      lock_ch   <= in_last[grant] ? lock_ch : grant;
      ptr       <= !in_last[grant] ? ptr : grant == WSEL'(INPUTS - 1) ? '0 : grant + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Registered, round-robin arbitrated N-to-1 multiplexer with per-channel valid/ready handshakes and packet locking.
- Generalises the combinational select mux:
  - Any INPUTS count from 2 to 32, not only 2/3/4/8/32.
  - Select is generated internally by a fair arbiter instead of being supplied.
  - One output register stage absorbs backpressure.
- Sits where several producers share one consumer (e.g. fetch/load/store requests to the memory bus, or writeback sources to the register file).

Parameters:
WIDTH, 32, data bits per channel
INPUTS, 8, number of input channels; legal 2..32, power of two not required
WSEL, $clog2(INPUTS), width of the channel index

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  WIDTH*INPUTS  channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  INPUTS  channel k presents a beat
in_last  input  INPUTS  beat on channel k ends its packet
in_ready  output  INPUTS  channel k beat accepted this cycle; at most one bit set
out_data  output  WIDTH  registered selected data
out_valid  output  1  output register holds a beat
out_last  output  1  registered in_last of the held beat
out_sel  output  WSEL  index of the channel the held beat came from
out_ready  input  1  consumer accepts the held beat

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Round-robin pointer ptr=0; lock=0; lock_ch=0.
  - in_ready=0 while reset is held.
- load_en = ~out_valid | out_ready. The output register loads whenever it is empty or drains this cycle. Full throughput: 1 beat/cycle.
- Grant selection (combinational):
  - If lock=1: grant=lock_ch, qualified by in_valid[lock_ch].
  - Else: grant = first k with in_valid[k]=1, searching ptr, ptr+1, ..., INPUTS-1, 0, ..., ptr-1.
- in_ready[k] = load_en & grant_valid & (grant==k). in_ready depends combinationally on out_ready; there must be no path from in_ready back into in_valid.
- Transfer on channel k (in_valid[k] & in_ready[k]) at the edge:
  - out_data <= in_data[k]; out_last <= in_last[k]; out_sel <= k; out_valid <= 1.
  - If in_last[k]=0: lock <= 1, lock_ch <= k.
  - If in_last[k]=1: lock <= 0; ptr <= (k==INPUTS-1) ? 0 : k+1.
- No transfer but out_ready=1: out_valid <= 0. out_data, out_last and out_sel hold their last values.
- Latency: a beat accepted at edge N appears on out_* immediately after edge N (1 cycle).
- Output stability: while out_valid=1 and out_ready=0, out_* must not change.
- Locked channel drops in_valid mid-packet: no other channel is granted. The output bubbles until lock_ch resumes. A packet is never interleaved.
- Single-beat packets (in_last=1) never set lock, so arbitration is fair per beat.
- Non-power-of-two INPUTS: ptr wraps INPUTS-1 -> 0. Indices >= INPUTS never appear on out_sel.
- Reset asserted mid-packet clears lock and discards the held beat. No partial state survives.
- Simultaneous drain and load in the same cycle: out_valid stays 1 and the new beat replaces the old one. No bubble.

Test Plan:
- Reset then single beat: INPUTS=8, WIDTH=32; in_valid=8'h04, in_data lane2=32'hDEADBEEF, in_last[2]=1, out_ready=1 -> in_ready=8'h04 for 1 cycle; next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=2, out_last=1; ptr=3.
- Fairness: all 8 channels valid, last=1 on every beat, out_ready=1 for 16 cycles -> out_sel sequence 0,1,...,7,0,...,7. Each in_ready bit is high exactly 2 times.
- Packet lock: ch1 sends a 3-beat packet (last=0,0,1) while ch0 and ch5 are continuously valid -> out_sel=1,1,1, then 5, then 0. Repeat with ch1 dropping in_valid for 2 cycles mid-packet -> out_valid=0 for those 2 cycles, and no grant to ch0 or ch5.
- Backpressure: beat from ch3 held with out_ready=0 for 5 cycles while ch4 is valid -> out_* stable, in_ready=0. When out_ready=1, ch4 is accepted the same cycle and out_sel=4 on the next cycle.
- Non-power-of-two: INPUTS=3; all valid, last=1 -> out_sel 0,1,2,0,1,2. out_sel never equals 3.
- Async reset mid-packet: assert reset between clock edges during a locked ch6 packet -> out_valid=0 and in_ready=0 immediately. After release with all channels valid -> first grant goes to ch0.
